// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, checksummed byte frame,
// writes little-endian words from address 0 and releases the CPU once the frame verifies.
module imem_loader #(
    parameter int ADDR_WIDTH = 10   // supported range 1..15 (word count must fit 16-bit LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic                  in_byte_valid,
    input  logic [7:0]            in_byte,
    output logic                  out_byte_ready,
    output logic                  out_mem_we,
    output logic [31:0]           out_mem_addr,
    output logic [31:0]           out_mem_wdata,
    output logic                  out_cpu_hold,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_error,
    output logic [ADDR_WIDTH:0]   out_word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0]         DEPTH_W = 17'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE     = 1;

    state_t                state_q, state_d;
    logic [7:0]            len_lo;
    logic [ADDR_WIDTH:0]   len_words;
    logic [23:0]           word_buf;
    logic [1:0]            byte_idx;
    logic [7:0]            sum;
    logic                  accept;
    logic [15:0]           len_n;
    logic                  len_too_big;
    logic                  last_word;

    assign out_byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                            (state_q == S_DATA)   || (state_q == S_CHECK);
    assign out_busy       = out_byte_ready;
    assign out_cpu_hold   = (state_q != S_DONE);

    assign accept      = in_byte_valid && out_byte_ready;
    assign len_n       = {in_byte, len_lo};
    assign len_too_big = {1'b0, len_n} > DEPTH_W;
    assign last_word   = (out_word_count + ONE) == len_words;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (in_start) begin
            state_d = S_LEN_LO;
        end else begin
            case (state_q)
                S_LEN_LO: if (accept) state_d = S_LEN_HI;
                S_LEN_HI: if (accept) begin
                    if (len_too_big)       state_d = S_ERROR;
                    else if (len_n == '0)  state_d = S_CHECK;
                    else                   state_d = S_DATA;
                end
                S_DATA:   if (accept && byte_idx == 2'd3 && last_word) state_d = S_CHECK;
                S_CHECK:  if (accept) state_d = (in_byte == sum) ? S_DONE : S_ERROR;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo         <= '0;
            len_words      <= '0;
            word_buf       <= '0;
            byte_idx       <= '0;
            sum            <= '0;
            out_mem_we     <= 1'b0;
            out_mem_addr   <= '0;
            out_mem_wdata  <= '0;
            out_done       <= 1'b0;
            out_error      <= 1'b0;
            out_word_count <= '0;
        end else begin
            out_mem_we <= 1'b0;
            if (in_start) begin
                // Restart discards any byte handshaked in this same cycle.
                sum            <= '0;
                byte_idx       <= '0;
                out_word_count <= '0;
                out_done       <= 1'b0;
                out_error      <= 1'b0;
            end else begin
                if (accept) begin
                    case (state_q)
                        S_LEN_LO: len_lo    <= in_byte;
                        S_LEN_HI: len_words <= len_n[ADDR_WIDTH:0];
                        S_DATA: begin
                            sum      <= sum + in_byte;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                // Word index is below DEPTH because LEN was bounded.
                                out_mem_we     <= 1'b1;
                                out_mem_addr   <= 32'({out_word_count[ADDR_WIDTH-1:0], 2'b00});
                                out_mem_wdata  <= {in_byte, word_buf};
                                out_word_count <= out_word_count + ONE;
                            end else begin
                                word_buf <= {in_byte, word_buf[23:8]};
                            end
                        end
                        default: ;
                    endcase
                end
                if (state_d == S_DONE  && state_q != S_DONE)  out_done  <= 1'b1;
                if (state_d == S_ERROR && state_q != S_ERROR) out_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as bytes are driven
// and compared when the write strobe appears; frame status is checked after each frame.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_start;
    logic          in_byte_valid;
    logic [7:0]    in_byte;
    logic          out_byte_ready;
    logic          out_mem_we;
    logic [31:0]   out_mem_addr;
    logic [31:0]   out_mem_wdata;
    logic          out_cpu_hold;
    logic          out_busy;
    logic          out_done;
    logic          out_error;
    logic [AW:0]   out_word_count;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] words[2];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_start(in_start),
        .in_byte_valid(in_byte_valid), .in_byte(in_byte),
        .out_byte_ready(out_byte_ready), .out_mem_we(out_mem_we),
        .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .out_cpu_hold(out_cpu_hold), .out_busy(out_busy),
        .out_done(out_done), .out_error(out_error),
        .out_word_count(out_word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_mem_we === 1'b1) begin
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check("write_addr_data", {out_mem_addr, out_mem_wdata}, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_byte_valid = 1'b0;
        repeat (gap) tick();
        in_byte_valid = 1'b1;
        in_byte       = b;
        check("ready_for_byte", 64'(out_byte_ready), 64'd1);
        tick();
    endtask

    // Sends LEN, nw words from `words`, then checksum ^ cs_xor; stops early after stop_after bytes.
    task automatic frame(input logic [15:0] n, input int nw, input logic [7:0] cs_xor,
                         input int max_gap, input int stop_after);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        int         k;
        cs = 8'h00;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < 4; b++) begin
                bytes.push_back(words[w][8*b +: 8]);
                cs = cs + words[w][8*b +: 8];
            end
        bytes.push_back(cs ^ cs_xor);
        for (int i = 0; i < bytes.size(); i++) begin
            if (stop_after >= 0 && i >= stop_after) break;
            if (i >= 2 && i < 2 + 4 * nw && (i - 2) % 4 == 3) begin
                k = (i - 2) / 4;
                exp_q.push_back({32'(k * 4), words[k]});
            end
            send(bytes[i], (max_gap > 0) ? int'($urandom_range(max_gap)) : 0);
        end
        in_byte_valid = 1'b0;
    endtask

    task automatic status(input string tag, input logic done, input logic err, input int wc);
        check({tag, "_done"},  64'(out_done),       64'(done));
        check({tag, "_error"}, 64'(out_error),      64'(err));
        check({tag, "_hold"},  64'(out_cpu_hold),   64'(!done));
        check({tag, "_ready"}, 64'(out_byte_ready), 64'd0);
        check({tag, "_busy"},  64'(out_busy),       64'd0);
        check({tag, "_wc"},    64'(out_word_count), 64'(wc));
        check({tag, "_q"},     64'(exp_q.size()),   64'd0);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_we"},    64'(out_mem_we),     64'd0);
        check({tag, "_addr"},  64'(out_mem_addr),   64'd0);
        check({tag, "_wdata"}, 64'(out_mem_wdata),  64'd0);
        check({tag, "_hold"},  64'(out_cpu_hold),   64'd1);
        check({tag, "_busy"},  64'(out_busy),       64'd0);
        check({tag, "_ready"}, 64'(out_byte_ready), 64'd0);
        check({tag, "_done"},  64'(out_done),       64'd0);
        check({tag, "_error"}, 64'(out_error),      64'd0);
        check({tag, "_wc"},    64'(out_word_count), 64'd0);
    endtask

    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        rst = 1'b0; in_start = 1'b0; in_byte_valid = 1'b0; in_byte = 8'h00;
        repeat (3) tick();
        reset_values("reset");
        rst = 1'b1;
        tick();
        check("idle_ready", 64'(out_byte_ready), 64'd0);

        // 1: two-word load with correct checksum B6
        pulse_start();
        check("start_busy", 64'(out_busy), 64'd1);
        frame(16'd2, 2, 8'h00, 0, -1);
        status("t1", 1'b1, 1'b0, 2);

        // 2: same frame with CS B7; writes still happen
        pulse_start();
        frame(16'd2, 2, 8'h01, 0, -1);
        status("t2", 1'b0, 1'b1, 2);

        // 3: N=1025 exceeds DEPTH -> error after LEN_HI, no writes
        pulse_start();
        frame(16'h0401, 0, 8'h00, 0, 2);
        status("t3", 1'b0, 1'b1, 0);

        // 4: empty frames
        pulse_start();
        frame(16'd0, 0, 8'h00, 0, -1);
        status("t4a", 1'b1, 1'b0, 0);
        pulse_start();
        frame(16'd0, 0, 8'h01, 0, -1);
        status("t4b", 1'b0, 1'b1, 0);

        // 5: random gaps, then full rate
        pulse_start();
        frame(16'd2, 2, 8'h00, 5, -1);
        status("t5gap", 1'b1, 1'b0, 2);
        pulse_start();
        frame(16'd2, 2, 8'h00, 0, -1);
        status("t5full", 1'b1, 1'b0, 2);

        // 6a: async reset after 6 bytes cancels the in-flight write
        pulse_start();
        frame(16'd2, 2, 8'h00, 0, 6);
        rst = 1'b0;
        #1;
        reset_values("t6rst");
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        pulse_start();
        frame(16'd2, 2, 8'h00, 0, -1);
        status("t6a", 1'b1, 1'b0, 2);

        // 6b: restart after 6 bytes; the first word's write already issued stands
        pulse_start();
        frame(16'd2, 2, 8'h00, 0, 6);
        pulse_start();
        check("t6b_restart_wc", 64'(out_word_count), 64'd0);
        check("t6b_restart_hold", 64'(out_cpu_hold), 64'd1);
        frame(16'd2, 2, 8'h00, 0, -1);
        status("t6b", 1'b1, 1'b0, 2);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
